// File: rtl/uart_rx_packer.sv
// uart_rx_packer: 8N1 UART receiver with mid-bit sampling that packs eight
// consecutive bytes (first byte in bits [7:0]) into a 64-bit word and hands it
// to the consumer over a valid/ready handshake.
module uart_rx_packer #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        frame_err,
  output logic [2:0]  byte_count,
  output logic [63:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        overrun
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  // Timer counts from 0, so a sample lands when it reaches N-1.
  localparam logic [15:0] HalfLast = 16'(HALF - 1);
  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  // Synchroniser and bit-level state.
  logic        rx_meta_q, rx_sync_q;
  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        byte_done, byte_bad;

  // Byte/word assembly state.
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_valid_q, byte_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [2:0]  byte_count_q, byte_count_d;
  logic [63:0] asm_q, asm_d;
  logic [63:0] word_data_q, word_data_d;
  logic        word_valid_q, word_valid_d;
  logic        overrun_q, overrun_d;
  logic [63:0] new_word;
  logic [5:0]  lane_lsb;

  // Two-flop synchroniser for the asynchronous rx pin; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Bit-level FSM state, bit timer, bit counter and data shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state: sample mid-bit, reload the timer at every sample point.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 16'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    byte_bad  = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d   = '0;
        bit_cnt_d = '0;
        if (!rx_sync_q) state_d = StStart;
      end
      StStart: begin
        if (timer_q == HalfLast) begin
          timer_d = '0;
          // A high line at mid-start is a glitch, not a frame.
          state_d = rx_sync_q ? StIdle : StData;
        end
      end
      StData: begin
        if (timer_q == BitLast) begin
          timer_d   = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (timer_q == BitLast) begin
          timer_d = '0;
          if (rx_sync_q) begin
            byte_done = 1'b1;
            state_d   = StIdle;
          end else begin
            byte_bad = 1'b1;
            state_d  = StBreak;
          end
        end
      end
      StBreak: begin
        timer_d = '0;
        // Hold off until the line returns high so a break yields no bytes.
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Word image with the freshly received byte dropped into its lane.
  always_comb begin
    lane_lsb = {byte_count_q, 3'b000};
    new_word = asm_q;
    new_word[lane_lsb +: 8] = shift_q;
  end

  // Byte reporting, word assembly and the output handshake.
  always_comb begin
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    byte_count_d = byte_count_q;
    asm_d        = asm_q;
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    overrun_d    = overrun_q;

    if (word_valid_q && word_ready) word_valid_d = 1'b0;

    if (byte_done) begin
      byte_data_d  = shift_q;
      byte_valid_d = 1'b1;
      byte_count_d = byte_count_q + 3'd1;
      asm_d        = new_word;
      if (byte_count_q == 3'd7) begin
        // Load only if the output slot is free or being emptied this cycle.
        if (!word_valid_q || word_ready) begin
          word_data_d  = new_word;
          word_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end

    if (byte_bad) begin
      // Drop the partial word so the next byte starts a fresh word.
      frame_err_d  = 1'b1;
      byte_count_d = '0;
      asm_d        = '0;
    end
  end

  // Output and assembly registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      byte_count_q <= '0;
      asm_q        <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      byte_count_q <= byte_count_d;
      asm_q        <= asm_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign byte_count = byte_count_q;
  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer at 16 clocks per bit.
module tb_uart_rx_packer;

  localparam int unsigned CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        word_ready = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        frame_err;
  logic [2:0]  byte_count;
  logic [63:0] word_data;
  logic        word_valid;
  logic        overrun;

  int          n_checks = 0;
  int          n_pass = 0;

  // Event tallies gathered on the falling edge, away from the active edge.
  int          cyc = 0;
  int          bv_cnt = 0;
  int          fe_cnt = 0;
  int          wv_cnt = 0;
  int          last_bv_cyc = 0;
  int          start_cyc = 0;
  logic [7:0]  last_byte = '0;
  logic [63:0] wv_word = '0;
  logic        wv_prev = 1'b0;

  int          bv_base, fe_base, wv_base;

  always #5 clk = ~clk;

  uart_rx_packer #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .byte_count(byte_count),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .overrun   (overrun)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (byte_valid) begin
      bv_cnt      = bv_cnt + 1;
      last_byte   = byte_data;
      last_bv_cyc = cyc;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (word_valid) begin
      wv_cnt = wv_cnt + 1;
      if (!wv_prev) wv_word = word_data;
    end
    wv_prev = word_valid;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance to just after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_byte_data", 64'(byte_data), 64'h0);
    check("rst_byte_valid", 64'(byte_valid), 64'h0);
    check("rst_frame_err", 64'(frame_err), 64'h0);
    check("rst_byte_count", 64'(byte_count), 64'h0);
    check("rst_word_data", word_data, 64'h0);
    check("rst_word_valid", 64'(word_valid), 64'h0);
    check("rst_overrun", 64'(overrun), 64'h0);
    repeat (5) tick();

    // Two bytes in, then reset in the middle of a third.
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    tick();
    check("pre_rst_count", 64'(byte_count), 64'h2);
    check("pre_rst_byte", 64'(byte_data), 64'h34);
    rx = 1'b0;
    repeat (3 * CPB) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("midrst_byte_data", 64'(byte_data), 64'h0);
    check("midrst_byte_count", 64'(byte_count), 64'h0);
    check("midrst_word_valid", 64'(word_valid), 64'h0);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (40) tick();
    check("midrst_no_byte", 64'(bv_cnt), 64'h2);

    // Single byte after reset, with latency from the pin edge.
    bv_base = bv_cnt;
    send_frame(8'h85, 1'b1);
    repeat (10) tick();
    check("single_byte", 64'(last_byte), 64'h85);
    check("single_pulses", 64'(bv_cnt - bv_base), 64'h1);
    check("single_latency", 64'(last_bv_cyc - start_cyc), 64'd155);
    check("single_count", 64'(byte_count), 64'h1);
    check("single_no_word", 64'(word_valid), 64'h0);

    // Eight back-to-back bytes with the consumer always ready.
    reset_dut();
    word_ready = 1'b1;
    wv_base = wv_cnt;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    send_frame(8'h56, 1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h85, 1'b1);
    send_frame(8'hAA, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (20) tick();
    check("word8_data", wv_word, 64'hFF00AA8511563412);
    check("word8_valid_cycles", 64'(wv_cnt - wv_base), 64'h1);
    check("word8_count", 64'(byte_count), 64'h0);
    check("word8_valid_low", 64'(word_valid), 64'h0);

    // Short low glitch must be rejected as a false start.
    bv_base = bv_cnt;
    fe_base = fe_cnt;
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (30) tick();
    check("glitch_no_byte", 64'(bv_cnt - bv_base), 64'h0);
    check("glitch_no_ferr", 64'(fe_cnt - fe_base), 64'h0);
    send_frame(8'h3C, 1'b1);
    repeat (5) tick();
    check("glitch_next_byte", 64'(last_byte), 64'h3C);
    check("glitch_next_pulses", 64'(bv_cnt - bv_base), 64'h1);
    check("glitch_next_count", 64'(byte_count), 64'h1);

    // Framing error followed by a held-low line, then a realigned word.
    reset_dut();
    send_frame(8'hA1, 1'b1);
    send_frame(8'hB2, 1'b1);
    send_frame(8'hC3, 1'b1);
    tick();
    check("ferr_pre_count", 64'(byte_count), 64'h3);
    bv_base = bv_cnt;
    fe_base = fe_cnt;
    send_frame(8'h55, 1'b0);
    repeat (40) tick();
    check("ferr_pulses", 64'(fe_cnt - fe_base), 64'h1);
    check("ferr_no_byte", 64'(bv_cnt - bv_base), 64'h0);
    check("ferr_count", 64'(byte_count), 64'h0);
    rx = 1'b1;
    repeat (20) tick();
    check("ferr_break_no_byte", 64'(bv_cnt - bv_base), 64'h0);
    wv_base = wv_cnt;
    for (int i = 0; i < 8; i++) send_frame(8'(i + 1), 1'b1);
    repeat (20) tick();
    check("ferr_realigned_word", wv_word, 64'h0807060504030201);
    check("ferr_word_cycles", 64'(wv_cnt - wv_base), 64'h1);

    // Overrun: consumer stalled across two words.
    reset_dut();
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1);
    for (int i = 0; i < 7; i++) send_frame(8'(8'hA0 + i), 1'b1);
    tick();
    check("ovr_before_16th", 64'(overrun), 64'h0);
    check("ovr_first_word_held", word_data, 64'h1716151413121110);
    send_frame(8'hA7, 1'b1);
    repeat (5) tick();
    check("ovr_set", 64'(overrun), 64'h1);
    check("ovr_valid_held", 64'(word_valid), 64'h1);
    check("ovr_word_kept", word_data, 64'h1716151413121110);
    check("ovr_count", 64'(byte_count), 64'h0);
    word_ready = 1'b1;
    tick();
    check("ovr_valid_drop", 64'(word_valid), 64'h0);
    check("ovr_sticky", 64'(overrun), 64'h1);
    repeat (5) tick();
    check("ovr_sticky_later", 64'(overrun), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_packer.md
# uart_rx_packer

- Receive-side counterpart of the UART transmit path.
- Recovers 8N1 bytes from the asynchronous `rx` line using a clock-divider bit timer with mid-bit sampling.
- Packs eight consecutive bytes into a 64-bit word, first byte received in bits [7:0], matching the LSB-first byte order the transmit buffer uses.
- Hands each completed word to the consumer over a valid/ready handshake. Sits between the board `Rx` pin and the consumer logic.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 5208: `clk` cycles per UART bit (50 MHz / 9600). Legal range 4..65535. `HALF` = floor(`CLKS_PER_BIT`/2).

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial input; idles high; asynchronous to `clk`.
- `byte_data`  out  8  last received byte.
- `byte_valid`  out  1  one-cycle pulse when `byte_data` is updated.
- `frame_err`  out  1  one-cycle pulse on a stop-bit error.
- `byte_count`  out  3  number of bytes in the partially assembled word.
- `word_data`  out  64  completed word; byte k is in bits [8k+7:8k].
- `word_valid`  out  1  completed word available.
- `word_ready`  in  1  consumer accepts the word.
- `overrun`  out  1  sticky; set when a completed word was dropped; cleared only by `rst`.

## Operation

Input synchronisation:
- `rx` passes through a 2-flop synchroniser (reset value 1). All references to `rx` below mean the synchronised signal.

Bit-level state machine:
- IDLE: bit counter cleared. `rx`=0 seen → START at cycle T0.
- START: at T0+`HALF`, sample `rx`.
  - 0 → DATA.
  - 1 → false start; return to IDLE. No output activity.
- DATA: bit i (i=0..7, LSB first) sampled at T0+`HALF`+(i+1)·`CLKS_PER_BIT`. After bit 7 → STOP.
- STOP: sample at T0+`HALF`+9·`CLKS_PER_BIT`.
  - 1 → byte good; return to IDLE.
  - 0 → frame error; go to BREAK.
- BREAK: wait until `rx`=1, then IDLE. A low line never produces a byte.

Good byte:
- `byte_data` loads the byte and `byte_valid` pulses.
- The byte is written into the assembly register at lane `byte_count`, and `byte_count` increments (wraps 7→0).
- When the 8th byte lands:
  - `word_valid`=0, or `word_valid`=1 with `word_ready`=1 in the same cycle → the assembly register (including the new byte) loads into `word_data` and `word_valid`=1.
  - Otherwise → the new word is dropped, `overrun` is set, and `word_data` is unchanged.

Frame error:
- `frame_err` pulses; no `byte_valid` is generated.
- `byte_count` resets to 0 and the partial word is discarded (realigns word boundaries).
- A word already in `word_data` is unaffected.

Handshake:
- A word transfers on any cycle with `word_valid` && `word_ready`.
- `word_valid` then drops the next cycle, unless a new word loads in that same cycle, in which case it stays high.
- `word_data` is held stable while `word_valid`=1.

Reset:
- `rst` asserted at any time, including mid-byte, immediately forces state IDLE and clears both counters and all registers.

## Timing

Reset values:
- `byte_data`=0, `byte_valid`=0, `frame_err`=0, `byte_count`=0, `word_data`=0, `word_valid`=0, `overrun`=0.
- Synchroniser flops=1.

Latency:
- `rx` pin edge to T0: 2–3 cycles (synchroniser).
- `byte_valid`, `byte_count` update, and `frame_err` are registered one cycle after the stop sample, i.e. at T0+`HALF`+9·`CLKS_PER_BIT`+1.
- `word_valid` rises in the same cycle as the 8th `byte_valid`.

Bit timer:
- 16-bit counter reloaded at every sample point.
- No accumulated drift beyond floor(`CLKS_PER_BIT`/2) rounding.

Back-to-back frames:
- A start bit beginning immediately after the stop bit is accepted: IDLE is re-entered before the mid-point of the next start bit.

## Test plan

All scenarios use `CLKS_PER_BIT`=16.

- Reset: assert `rst` mid-stream, hold 3 cycles → all outputs at reset values, no `byte_valid`. First frame after release is received correctly.
- Single byte 0x85 → `byte_data`=0x85, one `byte_valid` pulse 8+9·16+1 cycles after T0, `byte_count`=1, `word_valid`=0.
- Eight back-to-back bytes 0x12,0x34,0x56,0x11,0x85,0xAA,0x00,0xFF with `word_ready`=1 → `word_data`=0xFF00AA8511563412, `word_valid` high for exactly 1 cycle, `byte_count`=0.
- Glitch: `rx` low for 5 cycles → no `byte_valid`, no `frame_err`, FSM back in IDLE. Following byte 0x3C is received correctly.
- Framing error: 3 good bytes, then 0x55 with stop bit 0, line held low 40 cycles → one `frame_err` pulse, `byte_count`=0, no byte reported. Nothing received until `rx` returns high. Next 8 bytes form a correctly aligned word.
- Overrun: `word_ready`=0, send 16 bytes → first word held in `word_data`, `overrun`=1 at the 16th byte. Raise `word_ready` → `word_valid` drops next cycle, `overrun` stays 1.
